// File: rtl/ddr3_pkg.sv
// Shared RAM-port field widths and port indices for the DDR3 RAM arbiter.
package ddr3_pkg;
    localparam int ADDR_W = 32;
    localparam int STRB_W = 16;
    localparam int ID_W   = 16;
    localparam int DATA_W = 128;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // A port is requesting when it asserts any write strobe or a read.
    function automatic logic is_req(input logic [STRB_W-1:0] wr, input logic rd);
        return (|wr) | rd;
    endfunction
endpackage

// File: rtl/ddr3_ram_arb_if.sv
// One RAM request/response port (ddr3_core style); master issues requests.
interface ddr3_ram_arb_if;
    import ddr3_pkg::*;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wr;
    logic              rd;
    logic [ID_W-1:0]   req_id;
    logic [DATA_W-1:0] write_data;
    logic              accept;
    logic              ack;
    logic              error;
    logic [DATA_W-1:0] read_data;
    logic [ID_W-1:0]   resp_id;

    modport master (output addr, wr, rd, req_id, write_data,
                    input  accept, ack, error, read_data, resp_id);
    modport slave  (input  addr, wr, rd, req_id, write_data,
                    output accept, ack, error, read_data, resp_id);
endinterface

// File: rtl/ddr3_ram_arb_fifo.sv
// 1-bit-wide synchronous FIFO recording which port owns each in-flight request.
module ddr3_ram_arb_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) count_d = count_q + 1'b1;
        if (!push_ok && pop_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/ddr3_ram_arb.sv
// Two-port round-robin arbiter in front of the ddr3_core RAM port.
// Define DDR3_RAM_ARB_STATS_EN to add the stats_o per-port fire counters.
module ddr3_ram_arb
    import ddr3_pkg::*;
#(
    parameter int OUTSTANDING    = 4,
    parameter bit PORT0_PRIORITY = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
`ifdef DDR3_RAM_ARB_STATS_EN
    output logic [63:0]       stats_o,
`endif
    input  logic [ADDR_W-1:0] inport0_addr_i,
    input  logic [STRB_W-1:0] inport0_wr_i,
    input  logic              inport0_rd_i,
    input  logic [ID_W-1:0]   inport0_req_id_i,
    input  logic [DATA_W-1:0] inport0_write_data_i,
    output logic              inport0_accept_o,
    output logic              inport0_ack_o,
    output logic              inport0_error_o,
    output logic [DATA_W-1:0] inport0_read_data_o,
    output logic [ID_W-1:0]   inport0_resp_id_o,
    input  logic [ADDR_W-1:0] inport1_addr_i,
    input  logic [STRB_W-1:0] inport1_wr_i,
    input  logic              inport1_rd_i,
    input  logic [ID_W-1:0]   inport1_req_id_i,
    input  logic [DATA_W-1:0] inport1_write_data_i,
    output logic              inport1_accept_o,
    output logic              inport1_ack_o,
    output logic              inport1_error_o,
    output logic [DATA_W-1:0] inport1_read_data_o,
    output logic [ID_W-1:0]   inport1_resp_id_o,
    output logic [ADDR_W-1:0] outport_addr_o,
    output logic [STRB_W-1:0] outport_wr_o,
    output logic              outport_rd_o,
    output logic [ID_W-1:0]   outport_req_id_o,
    output logic [DATA_W-1:0] outport_write_data_o,
    input  logic              outport_accept_i,
    input  logic              outport_ack_i,
    input  logic              outport_error_i,
    input  logic [DATA_W-1:0] outport_read_data_i,
    input  logic [ID_W-1:0]   outport_resp_id_i
);
    // Handshake: a request is offered while wr/rd are non-zero and is taken
    // (fire) in any cycle the core raises accept; once offered, the grant and
    // its data source stay fixed until that fire.
    logic req0, req1, grant, fwd_valid, fire;
    logic fifo_full, fifo_empty, fifo_head;
    logic lock_q, lock_d, lock_port_q, lock_port_d;
    logic last_q, last_d, stray_q, stray_d;

    assign req0 = is_req(inport0_wr_i, inport0_rd_i);
    assign req1 = is_req(inport1_wr_i, inport1_rd_i);

    always_comb begin
        grant = PORT0;
        if (lock_q)             grant = lock_port_q;
        else if (req0 && req1)  grant = PORT0_PRIORITY ? PORT0 : ~last_q;
        else if (req1)          grant = PORT1;
    end

    assign fwd_valid = ((grant == PORT1) ? req1 : req0) & ~fifo_full;

    assign outport_addr_o       = (grant == PORT1) ? inport1_addr_i       : inport0_addr_i;
    assign outport_req_id_o     = (grant == PORT1) ? inport1_req_id_i     : inport0_req_id_i;
    assign outport_write_data_o = (grant == PORT1) ? inport1_write_data_i : inport0_write_data_i;
    assign outport_wr_o = !fwd_valid ? '0   : ((grant == PORT1) ? inport1_wr_i : inport0_wr_i);
    assign outport_rd_o = !fwd_valid ? 1'b0 : ((grant == PORT1) ? inport1_rd_i : inport0_rd_i);

    assign fire             = outport_accept_i & ((|outport_wr_o) | outport_rd_o);
    assign inport0_accept_o = fire & (grant == PORT0);
    assign inport1_accept_o = fire & (grant == PORT1);

    assign inport0_ack_o       = outport_ack_i & ~fifo_empty & (fifo_head == PORT0);
    assign inport1_ack_o       = outport_ack_i & ~fifo_empty & (fifo_head == PORT1);
    assign inport0_error_o     = outport_error_i;
    assign inport1_error_o     = outport_error_i;
    assign inport0_read_data_o = outport_read_data_i;
    assign inport1_read_data_o = outport_read_data_i;
    assign inport0_resp_id_o   = outport_resp_id_i;
    assign inport1_resp_id_o   = outport_resp_id_i;

    always_comb begin
        lock_d      = fwd_valid & ~fire;
        lock_port_d = grant;
        last_d      = fire ? grant : last_q;
        stray_d     = stray_q | (outport_ack_i & fifo_empty);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lock_q      <= 1'b0;
            lock_port_q <= PORT0;
            last_q      <= PORT1;
            stray_q     <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
            last_q      <= last_d;
            stray_q     <= stray_d;
        end
    end

    ddr3_ram_arb_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fire),
        .data_i  (grant),
        .pop_i   (outport_ack_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

`ifdef DDR3_RAM_ARB_STATS_EN
    logic [31:0] stat0_q, stat0_d, stat1_q, stat1_d;

    always_comb begin
        stat0_d = stat0_q;
        stat1_d = stat1_q;
        if (inport0_accept_o && stat0_q != 32'hFFFF_FFFF) stat0_d = stat0_q + 32'd1;
        if (inport1_accept_o && stat1_q != 32'hFFFF_FFFF) stat1_d = stat1_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign stats_o = {stat1_q, stat0_q};
`endif
endmodule

// File: tb/tb_ddr3_ram_arb.sv
// Randomised and directed bench for ddr3_ram_arb against a queue-based model.
module tb_ddr3_ram_arb;
  import ddr3_pkg::*;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  ddr3_ram_arb_if in0 ();
  ddr3_ram_arb_if in1 ();
  ddr3_ram_arb_if outp ();
`ifdef DDR3_RAM_ARB_STATS_EN
  logic [63:0] stats_o;
`endif

  ddr3_ram_arb #(.OUTSTANDING(4), .PORT0_PRIORITY(1'b0)) dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
`ifdef DDR3_RAM_ARB_STATS_EN
    .stats_o              (stats_o),
`endif
    .inport0_addr_i       (in0.addr),
    .inport0_wr_i         (in0.wr),
    .inport0_rd_i         (in0.rd),
    .inport0_req_id_i     (in0.req_id),
    .inport0_write_data_i (in0.write_data),
    .inport0_accept_o     (in0.accept),
    .inport0_ack_o        (in0.ack),
    .inport0_error_o      (in0.error),
    .inport0_read_data_o  (in0.read_data),
    .inport0_resp_id_o    (in0.resp_id),
    .inport1_addr_i       (in1.addr),
    .inport1_wr_i         (in1.wr),
    .inport1_rd_i         (in1.rd),
    .inport1_req_id_i     (in1.req_id),
    .inport1_write_data_i (in1.write_data),
    .inport1_accept_o     (in1.accept),
    .inport1_ack_o        (in1.ack),
    .inport1_error_o      (in1.error),
    .inport1_read_data_o  (in1.read_data),
    .inport1_resp_id_o    (in1.resp_id),
    .outport_addr_o       (outp.addr),
    .outport_wr_o         (outp.wr),
    .outport_rd_o         (outp.rd),
    .outport_req_id_o     (outp.req_id),
    .outport_write_data_o (outp.write_data),
    .outport_accept_i     (outp.accept),
    .outport_ack_i        (outp.ack),
    .outport_error_i      (outp.error),
    .outport_read_data_i  (outp.read_data),
    .outport_resp_id_i    (outp.resp_id)
  );

  // Reference model: owner of every in-flight request, oldest first.
  logic [0:0] exp_q[$];
  int         fire_log[$];
  bit         m_lock;
  int         m_lock_port;
  int         m_last;
  bit         m_stray;
  longint     m_stat0, m_stat1;
  int         n_total = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    in0.addr = '0; in0.wr = '0; in0.rd = 1'b0; in0.req_id = '0; in0.write_data = '0;
    in1.addr = '0; in1.wr = '0; in1.rd = 1'b0; in1.req_id = '0; in1.write_data = '0;
    outp.accept = 1'b0; outp.ack = 1'b0; outp.error = 1'b0;
    outp.read_data = '0; outp.resp_id = '0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    fire_log.delete();
    m_lock = 1'b0; m_lock_port = 0; m_last = 1; m_stray = 1'b0;
    m_stat0 = 0; m_stat1 = 0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b1;
    model_reset();
  endtask

  // Called at posedge+1 with inputs already driven; checks, advances model and clock.
  task automatic step();
    bit r0, r1, wreq, full, fwd, fire, q_has;
    int w;
    logic [STRB_W-1:0] wr_w;
    logic rd_w;
    #1;
    r0 = (in0.wr != 0) || in0.rd;
    r1 = (in1.wr != 0) || in1.rd;
    if (m_lock) w = m_lock_port;
    else if (r0 && r1) w = (m_last == 0) ? 1 : 0;
    else w = r1 ? 1 : 0;
    wreq = (w == 1) ? r1 : r0;
    wr_w = (w == 1) ? in1.wr : in0.wr;
    rd_w = (w == 1) ? in1.rd : in0.rd;
    full = (exp_q.size() == 4);
    fwd  = wreq && !full;
    fire = fwd && outp.accept;
    q_has = exp_q.size() > 0;

    check("out_addr", outp.addr, (w == 1) ? in1.addr : in0.addr);
    check("out_req_id", outp.req_id, (w == 1) ? in1.req_id : in0.req_id);
    check("out_wdata", outp.write_data, (w == 1) ? in1.write_data : in0.write_data);
    check("out_wr", outp.wr, fwd ? wr_w : 16'h0);
    check("out_rd", outp.rd, fwd ? rd_w : 1'b0);
    check("accept0", in0.accept, fire && w == 0);
    check("accept1", in1.accept, fire && w == 1);
    check("ack0", in0.ack, outp.ack && q_has && exp_q[0] == 0);
    check("ack1", in1.ack, outp.ack && q_has && exp_q[0] == 1);
    check("err_bcast", {in1.error, in0.error}, {outp.error, outp.error});
    check("rdata0", in0.read_data, outp.read_data);
    check("rdata1", in1.read_data, outp.read_data);
    check("resp_id", {in1.resp_id, in0.resp_id}, {outp.resp_id, outp.resp_id});
    check("count", dut.u_fifo.count_q, exp_q.size());
    check("stray", dut.stray_q, m_stray);
`ifdef DDR3_RAM_ARB_STATS_EN
    check("stats", stats_o, {m_stat1[31:0], m_stat0[31:0]});
`endif

    if (outp.ack) begin
      if (q_has) void'(exp_q.pop_front());
      else m_stray = 1'b1;
    end
    if (fire) begin
      exp_q.push_back(w[0:0]);
      fire_log.push_back(w);
      m_last = w;
      if (w == 0 && m_stat0 < 64'hFFFF_FFFF) m_stat0++;
      if (w == 1 && m_stat1 < 64'hFFFF_FFFF) m_stat1++;
    end
    m_lock = fwd && !fire;
    m_lock_port = w;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      outp.ack = 1'b1;
      outp.resp_id = 16'(i);
      outp.read_data = {4{$urandom}};
      step();
    end
    outp.ack = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    @(posedge clk); #1;
    do_reset();
    step();

    // Single read from port 0, response two cycles later.
    in0.rd = 1'b1; in0.addr = 32'h100; outp.accept = 1'b1;
    step();
    idle_inputs();
    step();
    outp.ack = 1'b1; outp.resp_id = 16'h0005;
    step();
    idle_inputs();
    check("t1_fires", fire_log.size(), 1);
    check("t1_port", fire_log[0], 0);

    // Continuous contention alternates starting from port 0.
    do_reset();
    in0.rd = 1'b1; in0.addr = 32'h1000; in1.wr = 16'hFFFF; in1.addr = 32'h2000;
    outp.accept = 1'b1;
    repeat (4) step();
    idle_inputs();
    drain(4);
    check("t2_fires", fire_log.size(), 4);
    for (int i = 0; i < 4 && i < fire_log.size(); i++) check("t2_order", fire_log[i], i % 2);

    // Backpressure: grant held on port 0 while port 1 joins.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      in0.rd = 1'b1; in0.addr = 32'h200;
      if (c >= 2) begin in1.rd = 1'b1; in1.addr = 32'h300; end
      step();
    end
    outp.accept = 1'b1;
    step();
    step();
    idle_inputs();
    check("t3_fires", fire_log.size(), 2);
    if (fire_log.size() == 2) begin
      check("t3_first", fire_log[0], 0);
      check("t3_second", fire_log[1], 1);
    end
    drain(2);

    // Fill the outstanding FIFO, then free one slot.
    do_reset();
    in0.wr = 16'h00FF; in0.addr = 32'h400; outp.accept = 1'b1;
    repeat (5) step();
    check("t4_full_fires", fire_log.size(), 4);
    outp.ack = 1'b1;
    step();
    outp.ack = 1'b0;
    step();
    check("t4_after_ack", fire_log.size(), 5);
    idle_inputs();
    drain(4);

    // Stray ack with nothing outstanding.
    do_reset();
    outp.ack = 1'b1;
    step();
    outp.ack = 1'b0;
    step();
    check("t5_stray_set", dut.stray_q, 1'b1);

    // Reset with requests outstanding.
    do_reset();
    in1.rd = 1'b1; in1.addr = 32'h500; outp.accept = 1'b1;
    repeat (3) step();
    check("t6_inflight", dut.u_fifo.count_q, 3);
    do_reset();
    step();
    check("t6_count_cleared", dut.u_fifo.count_q, 0);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      in0.wr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      in0.rd = ($urandom_range(0, 2) == 0);
      in0.addr = $urandom; in0.req_id = 16'($urandom); in0.write_data = {4{$urandom}};
      in1.wr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      in1.rd = ($urandom_range(0, 2) == 0);
      in1.addr = $urandom; in1.req_id = 16'($urandom); in1.write_data = {4{$urandom}};
      outp.accept = ($urandom_range(0, 1) == 1);
      outp.ack = (exp_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      outp.error = ($urandom_range(0, 7) == 0);
      outp.read_data = {$urandom, $urandom, $urandom, $urandom};
      outp.resp_id = 16'($urandom);
      step();
    end
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/ddr3_ram_arb.md
Name: ddr3_ram_arb

Overview:
- Two-requester arbiter in front of ddr3_core's RAM request port (addr/wr/rd/req_id/write_data, accept/ack/error/read_data/resp_id).
- Lets an AXI-pmem path and a second master (e.g. DMA or debug) share one DDR3 controller.
- Round-robin grant, held stable until accepted.
- Responses return in order and are routed back through an outstanding-source FIFO.

Parameters:
- OUTSTANDING, 4, max in-flight requests tracked; power of 2, 2..16.
- PORT0_PRIORITY, 0, 1 = port 0 wins every contention; 0 = round-robin.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-low reset.
- inportN_addr_i (N=0,1)  input  32  byte address.
- inportN_wr_i  input  16  byte write strobes; non-zero = write request.
- inportN_rd_i  input  1  read request.
- inportN_req_id_i  input  16  request tag.
- inportN_write_data_i  input  128  write data.
- inportN_accept_o  output  1  request taken this cycle.
- inportN_ack_o  output  1  response valid.
- inportN_error_o  output  1  response error.
- inportN_read_data_o  output  128  read data.
- inportN_resp_id_o  output  16  response tag.
- outport_addr_o / _wr_o / _rd_o / _req_id_o / _write_data_o  output  32/16/1/16/128  to core.
- outport_accept_i / _ack_i / _error_i  input  1 each  from core.
- outport_read_data_i / _resp_id_i  input  128/16  from core.

Behaviour:
- Request from port N: reqN = (|inportN_wr_i) | inportN_rd_i.
- Grant selection:
  - If lock_q is set, grant = lock_port_q.
  - Otherwise grant = the single requester.
  - On contention: port 0 if PORT0_PRIORITY, else the port != last_q.
- Forwarding: outport_* = mux of the granted port's fields. outport_wr_o and outport_rd_o are forced to 0 when no request is present or fifo_full.
- Handshake: fire = outport_accept_i & (|outport_wr_o | outport_rd_o). inportN_accept_o = fire & (grant==N). There is no combinational path from ack to accept.
- Lock: next lock_q = request forwarded & !fire. This holds grant and data source stable across core backpressure. When fire occurs, lock clears and last_q <= grant.
- Source FIFO:
  - Depth OUTSTANDING, 1 bit per entry (port id).
  - Push on fire. Pop on outport_ack_i.
  - fifo_full = count==OUTSTANDING. There is no same-cycle pop bypass when full.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo OUTSTANDING; count is $clog2(OUTSTANDING)+1 bits.
- Response routing:
  - inportN_ack_o = outport_ack_i & (head==N) & !fifo_empty.
  - error, read_data and resp_id are broadcast to both ports; only the acked port's ack is high.
- Stray ack (outport_ack_i while fifo_empty): dropped, no pop, sticky internal flag stray_q set. stray_q is observable via hierarchy for verification.
- Latency: 0 cycles request→outport (combinational); 0 cycles outport ack→inport ack.
- Reset (rst_i==0 at posedge):
  - lock_q=0, last_q=1 (port 0 wins first contention), FIFO pointers and count=0, stray_q=0.
  - Outputs follow: all accepts and acks 0, outport_wr_o=0, outport_rd_o=0.
- Reset mid-transaction discards in-flight tracking. The core must be reset in the same cycle.

Optional Feature:
- DDR3_RAM_ARB_STATS_EN defined adds output stats_o [63:0]:
  - [31:0] = count of port-0 fires, [63:32] = count of port-1 fires.
  - Saturating at 32'hFFFF_FFFF, cleared on reset.
- Undefined: the port and the counters are absent.

Decomposition:
- Shared package ddr3_pkg: RAM field widths (ADDR_W=32, STRB_W=16, ID_W=16, DATA_W=128) and port-index localparams.
- One sub-module, ddr3_ram_arb_fifo: a generic 1-bit-wide, OUTSTANDING-deep synchronous FIFO with push, pop, full, empty and head.

Test Plan:
- Port0 rd addr 0x100, accept_i=1 → outport_rd_o=1 at addr 0x100 same cycle, inport0_accept_o=1; ack_i two cycles later with resp_id 0x0005 → inport0_ack_o=1, inport1_ack_o=0.
- Both ports request continuously, accept_i=1, PORT0_PRIORITY=0 → fires alternate 0,1,0,1; acks route in the same order.
- accept_i held 0 for 5 cycles while port 0 requests and port 1 requests from cycle 2 → grant stays port 0 and outport_addr_o is stable; port 0 fires first when accept_i rises.
- OUTSTANDING=4, four fires with no ack → outport_wr_o=0, outport_rd_o=0 and no accept; one ack → the next request fires the following cycle.
- outport_ack_i pulse with FIFO empty → no inport ack, count stays 0, stray_q=1.
- rst_i=0 with 3 requests outstanding → count=0, all outputs idle next cycle; with DDR3_RAM_ARB_STATS_EN, stats_o=0.
